calc_sequencer: RTL and testbench
=================================

Name: calc_sequencer

Overview:
- Sequencing controller for the 4-bit signed add/subtract calculator datapath.
- Debounces and edge-detects the confirm and display-mode buttons.
- Steps operand entry (A, then B) through a state machine and latches the operator.
- Computes a registered 6-bit signed result and drives the value and radix mode consumed by the seven-segment display controller.

Parameters:
- DEBOUNCE_CYCLES, 1000000, consecutive clocks a synchronized button level must differ from its debounced level before the debounced level flips (10 ms at 100 MHz); legal range 2 or more.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- confirm  input  1  raw confirm button (BTNU), asynchronous, bouncy
- display_mode_change  input  1  raw display-mode button (BTND), asynchronous, bouncy
- operator_select  input  1  0 = add, 1 = subtract (sw[4])
- operand_input  input  4  signed two's-complement operand, range -8..7 (sw[3:0])
- display_result  output  6  signed value to display
- display_mode  output  1  0 = decimal, 1 = hex
- state_out  output  2  current FSM state encoding
- result_valid  output  1  high while a computed result is displayed

Behaviour:
- Reset (synchronous, active-high):
  - State = ENTER_A; operand A, operand B and operator registers = 0.
  - display_result = 0, display_mode = 0, result_valid = 0, state_out = 2'b00.
  - Both synchronizers, debounced levels and debounce counters = 0.
  - Reset has priority over every other event in the same cycle.
  - Reset mid-operation discards any partial entry.
- Button conditioning, identical per button:
  - Two-flop synchronizer: s1, s2.
  - Counter increments on each edge where s2 != db and clears on each edge where s2 == db.
  - When s2 != db and counter == DEBOUNCE_CYCLES-1: db <= s2 and counter <= 0.
  - Press pulse = db & ~db_d, one cycle wide, rising edge only; release generates no pulse.
  - Timing: raw high sampled at edge 1 gives db high after edge 2+DEBOUNCE_CYCLES; the pulse is high in the following cycle and the FSM acts on edge 3+DEBOUNCE_CYCLES.
  - Any bounce shorter than DEBOUNCE_CYCLES produces no pulse.
  - A button held through reset release registers as exactly one press.
- FSM states: ENTER_A = 00, ENTER_B = 01, SHOW_RESULT = 10; 11 is unreachable and recovers to ENTER_A next edge.
  - ENTER_A: display_result <= sign-extended operand_input each edge. On confirm pulse: A <= operand_input, go to ENTER_B.
  - ENTER_B: display_result <= sign-extended operand_input each edge. On confirm pulse: latch B and operator; result <= A+B or A-B (6-bit signed, computed from sign-extended operands); display_result <= that result on the same edge; result_valid <= 1; go to SHOW_RESULT.
  - SHOW_RESULT: display_result holds the result; operand and operator switch changes are ignored. On confirm pulse: result_valid <= 0, go to ENTER_A.
- Arithmetic:
  - Range is -16..14 for add and -15..15 for subtract, so no overflow is possible in 6 bits.
  - The operator is sampled only at the ENTER_B confirm.
- Display mode:
  - Each display_mode_change pulse toggles display_mode in any state.
  - Display mode is independent of the FSM; a simultaneous confirm pulse and mode pulse are both applied on the same edge.
- Output latency: every output is registered; a switch change appears on display_result one edge later while in an ENTER state.

Test Plan (DEBOUNCE_CYCLES = 4):
1. Reset, then operand_input = 4'b0011 -> display_result = 3 after one edge; state_out = 00; display_mode = 0; result_valid = 0.
2. Enter A = 7, confirm; B = -8 (4'b1000), operator_select = 1, confirm -> display_result = 15 (6'b001111), result_valid = 1, state_out = 10. Repeat with A = -8, B = -8, add -> -16 (6'b110000).
3. Confirm raw toggling 1,0,1,0 with 2-cycle periods, then held high -> exactly one pulse, at edge 3+4 after the stable level begins; state advances once.
4. display_mode_change pressed in ENTER_B, and again simultaneously with a confirm pulse -> display_mode goes 0→1, then 1→0 on the same edge that state moves to SHOW_RESULT.
5. In SHOW_RESULT, change switches -> display_result unchanged. Confirm -> state_out = 00, result_valid = 0, display_result tracks the switches.
6. Assert reset while in ENTER_B with A = 5 latched -> all outputs return to reset values. Confirm held across reset release -> one press; state goes to ENTER_B with A = current switches.

Source files
------------

// File: rtl/calc_sequencer_if.sv
// Operator-facing bus of the calculator sequencer: raw buttons and switches in,
// display value and status out.
interface calc_sequencer_if;
   logic       confirm;
   logic       display_mode_change;
   logic       operator_select;
   logic [3:0] operand_input;
   logic [5:0] display_result;
   logic       display_mode;
   logic [1:0] state_out;
   logic       result_valid;

   modport master (
      output confirm, display_mode_change, operator_select, operand_input,
      input  display_result, display_mode, state_out, result_valid
   );

   modport slave (
      input  confirm, display_mode_change, operator_select, operand_input,
      output display_result, display_mode, state_out, result_valid
   );
endinterface

// File: rtl/calc_sequencer.sv
// Sequencing controller for the 4-bit signed add/subtract calculator:
// button conditioning, operand entry FSM, registered result and display mode.
module calc_sequencer #(
   parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
   input  logic            clk,
   input  logic            reset,
   calc_sequencer_if.slave bus
);

   localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES);
   localparam int unsigned NBTN  = 2;
   localparam int unsigned BTN_CONFIRM = 0;
   localparam int unsigned BTN_MODE    = 1;

   typedef enum logic [1:0] {
      ENTER_A     = 2'b00,
      ENTER_B     = 2'b01,
      SHOW_RESULT = 2'b10
   } state_t;

   logic [NBTN-1:0]  btn_raw;
   logic [NBTN-1:0]  s1, s2, db, db_d;
   logic [CNT_W-1:0] cnt [NBTN];
   logic [NBTN-1:0]  press_c;

   state_t           state, state_n;
   logic [3:0]       op_a, op_a_n;
   logic [3:0]       op_b, op_b_n;
   logic             oper, oper_n;
   logic [5:0]       disp, disp_n;
   logic             valid, valid_n;
   logic             mode, mode_n;
   logic [5:0]       a_ext_c, b_ext_c, result_c;

   assign btn_raw = {bus.display_mode_change, bus.confirm};

   // Synchronize, debounce and rising-edge detect each button.
   always_ff @(posedge clk) begin
      if (reset) begin
         s1   <= '0;
         s2   <= '0;
         db   <= '0;
         db_d <= '0;
         for (int i = 0; i < int'(NBTN); i++) cnt[i] <= '0;
      end else begin
         s1   <= btn_raw;
         s2   <= s1;
         db_d <= db;
         for (int i = 0; i < int'(NBTN); i++) begin
            if (s2[i] == db[i]) begin
               cnt[i] <= '0;
            end else if (cnt[i] == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
               db[i]  <= s2[i];
               cnt[i] <= '0;
            end else begin
               cnt[i] <= cnt[i] + CNT_W'(1);
            end
         end
      end
   end

   assign press_c = db & ~db_d;

   // Sign-extended operands; B comes straight from the switches at the confirm edge.
   assign a_ext_c  = {{2{op_a[3]}}, op_a};
   assign b_ext_c  = {{2{bus.operand_input[3]}}, bus.operand_input};
   assign result_c = bus.operator_select ? (a_ext_c - b_ext_c) : (a_ext_c + b_ext_c);

   // State and registered outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= ENTER_A;
         op_a  <= '0;
         op_b  <= '0;
         oper  <= 1'b0;
         disp  <= '0;
         valid <= 1'b0;
         mode  <= 1'b0;
      end else begin
         state <= state_n;
         op_a  <= op_a_n;
         op_b  <= op_b_n;
         oper  <= oper_n;
         disp  <= disp_n;
         valid <= valid_n;
         mode  <= mode_n;
      end
   end

   always_comb begin
      state_n = state;
      op_a_n  = op_a;
      op_b_n  = op_b;
      oper_n  = oper;
      disp_n  = disp;
      valid_n = valid;
      mode_n  = mode ^ press_c[BTN_MODE];

      case (state)
         ENTER_A: begin
            disp_n = {{2{bus.operand_input[3]}}, bus.operand_input};
            if (press_c[BTN_CONFIRM]) begin
               op_a_n  = bus.operand_input;
               state_n = ENTER_B;
            end
         end
         ENTER_B: begin
            disp_n = {{2{bus.operand_input[3]}}, bus.operand_input};
            if (press_c[BTN_CONFIRM]) begin
               op_b_n  = bus.operand_input;
               oper_n  = bus.operator_select;
               disp_n  = result_c;
               valid_n = 1'b1;
               state_n = SHOW_RESULT;
            end
         end
         SHOW_RESULT: begin
            if (press_c[BTN_CONFIRM]) begin
               valid_n = 1'b0;
               state_n = ENTER_A;
            end
         end
         default: begin
            valid_n = 1'b0;
            state_n = ENTER_A;
         end
      endcase
   end

   assign bus.display_result = disp;
   assign bus.display_mode   = mode;
   assign bus.state_out      = state;
   assign bus.result_valid   = valid;

endmodule

// File: tb/tb_calc_sequencer.sv
// Self-checking bench for calc_sequencer: direct checks plus a result scoreboard.
module tb_calc_sequencer;

   localparam int unsigned DB = 4;

   logic clk = 1'b0;
   logic reset;
   int   n_tests = 0;
   int   n_fail  = 0;
   logic [5:0] sb_q [$];
   logic       prev_valid = 1'b0;
   bit         done = 1'b0;
   int         a_val;

   calc_sequencer_if cif ();

   calc_sequencer #(.DEBOUNCE_CYCLES(DB)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (cif.slave)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic press_confirm();
      cif.confirm = 1'b1;
      tick(12);
      cif.confirm = 1'b0;
      tick(12);
   endtask

   // Expected result pushed when B is confirmed, using bench-side arithmetic.
   task automatic push_result(input int a, input int b, input bit sub);
      int r;
      r = sub ? (a - b) : (a + b);
      sb_q.push_back(6'(r));
   endtask

   // Scoreboard: compare on each rising edge of result_valid.
   initial begin
      while (!done) begin
         @(negedge clk);
         if (cif.result_valid && !prev_valid) begin
            if (sb_q.size() == 0) check("sb_unexpected_result", 32'(cif.display_result), 32'hFFFF);
            else check("sb_result", 32'(cif.display_result), 32'(sb_q.pop_front()));
         end
         prev_valid = cif.result_valid;
      end
   end

   initial begin
      reset                   = 1'b1;
      cif.confirm             = 1'b0;
      cif.display_mode_change = 1'b0;
      cif.operator_select     = 1'b0;
      cif.operand_input       = 4'd0;
      tick(3);
      check("rst_disp",  32'(cif.display_result), 0);
      check("rst_mode",  32'(cif.display_mode), 0);
      check("rst_valid", 32'(cif.result_valid), 0);
      check("rst_state", 32'(cif.state_out), 0);

      // 1: switch tracking in ENTER_A
      reset = 1'b0;
      cif.operand_input = 4'b0011;
      tick(1);
      check("t1_disp",  32'(cif.display_result), 3);
      check("t1_state", 32'(cif.state_out), 0);
      check("t1_valid", 32'(cif.result_valid), 0);

      // 2: 7 - (-8) = 15, then -8 + -8 = -16
      cif.operand_input = 4'd7;
      press_confirm();
      check("t2_state_b", 32'(cif.state_out), 1);
      cif.operand_input = 4'b1000;
      cif.operator_select = 1'b1;
      push_result(7, -8, 1'b1);
      press_confirm();
      check("t2_disp15",  32'(cif.display_result), 15);
      check("t2_valid",   32'(cif.result_valid), 1);
      check("t2_state_r", 32'(cif.state_out), 2);
      press_confirm();
      check("t2_state_a", 32'(cif.state_out), 0);
      cif.operator_select = 1'b0;
      press_confirm();
      push_result(-8, -8, 1'b0);
      press_confirm();
      check("t2_disp_m16", 32'(cif.display_result), 32'(6'b110000));
      press_confirm();

      // 3: bounce then stable high gives one press at edge 3+DB
      cif.operand_input = 4'd2;
      for (int i = 0; i < 2; i++) begin
         cif.confirm = 1'b1; tick(2);
         cif.confirm = 1'b0; tick(2);
      end
      cif.confirm = 1'b1;
      tick(2 + DB);
      check("t3_before_edge", 32'(cif.state_out), 0);
      tick(1);
      check("t3_at_edge", 32'(cif.state_out), 1);
      tick(10);
      check("t3_single", 32'(cif.state_out), 1);
      cif.confirm = 1'b0;
      tick(12);

      // 4: mode toggle alone, then together with confirm
      cif.display_mode_change = 1'b1;
      tick(3 + DB);
      check("t4_mode_on", 32'(cif.display_mode), 1);
      cif.display_mode_change = 1'b0;
      tick(12);
      cif.operand_input = 4'b1101;
      cif.operator_select = 1'b0;
      push_result(2, -3, 1'b0);
      cif.confirm = 1'b1;
      cif.display_mode_change = 1'b1;
      tick(2 + DB);
      check("t4_mode_pre",  32'(cif.display_mode), 1);
      check("t4_state_pre", 32'(cif.state_out), 1);
      tick(1);
      check("t4_mode_post",  32'(cif.display_mode), 0);
      check("t4_state_post", 32'(cif.state_out), 2);
      cif.confirm = 1'b0;
      cif.display_mode_change = 1'b0;
      tick(12);

      // 5: switches ignored in SHOW_RESULT
      cif.operand_input = 4'd5;
      cif.operator_select = 1'b1;
      tick(3);
      check("t5_hold", 32'(cif.display_result), 32'(6'h3F));
      press_confirm();
      check("t5_state", 32'(cif.state_out), 0);
      check("t5_valid", 32'(cif.result_valid), 0);
      check("t5_track", 32'(cif.display_result), 5);

      // 6: reset in ENTER_B, confirm held through reset release
      press_confirm();
      check("t6_in_b", 32'(cif.state_out), 1);
      reset = 1'b1;
      tick(2);
      check("t6_rst_disp",  32'(cif.display_result), 0);
      check("t6_rst_state", 32'(cif.state_out), 0);
      check("t6_rst_mode",  32'(cif.display_mode), 0);
      check("t6_rst_valid", 32'(cif.result_valid), 0);
      cif.confirm = 1'b1;
      tick(2);
      a_val = 6;
      cif.operand_input = 4'(a_val);
      reset = 1'b0;
      tick(20);
      check("t6_one_press", 32'(cif.state_out), 1);
      cif.confirm = 1'b0;
      tick(12);
      cif.operand_input = 4'd1;
      cif.operator_select = 1'b0;
      push_result(a_val, 1, 1'b0);
      press_confirm();
      check("t6_result", 32'(cif.display_result), 7);

      done = 1'b1;
      tick(2);
      check("sb_drain", 32'(sb_q.size()), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
